// File: rtl/img_pkg.sv
// Shared image-pipeline types and constants for the median filter and its output serializer.
package img_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned IMG_SIZE = 100;
    localparam int unsigned FILT_W   = IMG_SIZE - 2;

    typedef logic [PIX_W-1:0] pixel_t;

    // Row-buffer occupancy doubles as the serializer state.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_row_serializer_if.sv
// Row-in / pixel-out handshake bundle between the median filter, serializer and pixel sink.
interface median_row_serializer_if #(
    parameter int unsigned WIDTH = img_pkg::FILT_W,
    parameter int unsigned PIX_W = img_pkg::PIX_W
);
    logic [PIX_W-1:0] row_in [WIDTH-1:0];
    logic             row_valid;
    logic             row_ready;
    logic [PIX_W-1:0] pix_out;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_eol;
    logic             pix_eof;
    logic             frame_done;

    modport master (
        output row_in, row_valid, pix_ready,
        input  row_ready, pix_out, pix_valid, pix_eol, pix_eof, frame_done
    );

    modport slave (
        input  row_in, row_valid, pix_ready,
        output row_ready, pix_out, pix_valid, pix_eol, pix_eof, frame_done
    );
endinterface

// File: rtl/row_pingpong_buf.sv
// Two-slot row buffer: rows are written into alternating slots and read back pixel by pixel.
module row_pingpong_buf
    import img_pkg::*;
#(
    parameter int unsigned WIDTH = FILT_W,
    parameter int unsigned PIX_W = img_pkg::PIX_W,
    parameter int unsigned COL_W = cnt_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [PIX_W-1:0] row_i [WIDTH-1:0],
    input  logic             pop_i,
    input  logic [COL_W-1:0] col_i,
    output logic [PIX_W-1:0] pix_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PIX_W-1:0] slot_q [2][WIDTH-1:0];
    occ_e             occ_q, occ_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;

    always_comb begin
        occ_d    = occ_q;
        wr_sel_d = wr_sel_q ^ push_i;
        rd_sel_d = rd_sel_q ^ pop_i;
        unique case ({push_i, pop_i})
            2'b10:   occ_d = (occ_q == StEmpty) ? StOne : StFull;
            2'b01:   occ_d = (occ_q == StFull) ? StOne : StEmpty;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q    <= StEmpty;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Row storage carries no reset; contents are only observed once occupancy says valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            slot_q[wr_sel_q] <= row_i;
        end
    end

    assign pix_o   = slot_q[rd_sel_q][col_i];
    assign full_o  = (occ_q == StFull);
    assign empty_o = (occ_q == StEmpty);

endmodule

// File: rtl/median_row_serializer.sv
// Accepts whole filtered rows and streams them out one pixel per cycle with row/frame markers.
module median_row_serializer
    import img_pkg::*;
#(
    parameter int unsigned WIDTH = FILT_W,
    parameter int unsigned ROWS  = FILT_W,
    parameter int unsigned PIX_W = img_pkg::PIX_W
) (
    input logic                     clk,
    input logic                     rst,
    median_row_serializer_if.slave  bus_io
);

    localparam int unsigned ColW = cnt_w(WIDTH);
    localparam int unsigned RowW = cnt_w(ROWS);

    logic            full, empty;
    logic            accept, pop, row_done, last_col, last_row;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            frame_done_q, frame_done_d;

    row_pingpong_buf #(
        .WIDTH (WIDTH),
        .PIX_W (PIX_W),
        .COL_W (ColW)
    ) u_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (accept),
        .row_i   (bus_io.row_in),
        .pop_i   (row_done),
        .col_i   (col_q),
        .pix_o   (bus_io.pix_out),
        .full_o  (full),
        .empty_o (empty)
    );

    // Ready comes from registered occupancy only, so a release while full frees the slot a
    // cycle later.
    assign bus_io.row_ready  = !full;
    assign bus_io.pix_valid  = !empty;
    assign accept            = bus_io.row_valid && bus_io.row_ready;
    assign pop               = bus_io.pix_valid && bus_io.pix_ready;
    assign last_col          = (col_q == ColW'(WIDTH - 1));
    assign last_row          = (row_q == RowW'(ROWS - 1));
    assign row_done          = pop && last_col;
    assign bus_io.pix_eol    = bus_io.pix_valid && last_col;
    assign bus_io.pix_eof    = bus_io.pix_valid && last_col && last_row;
    assign bus_io.frame_done = frame_done_q;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = pop && bus_io.pix_eof;
        if (pop) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The filter upstream cannot stall, so an offered row while full is silently lost.
    a_no_drop : assert property (@(posedge clk) disable iff (rst)
        !(bus_io.row_valid && !bus_io.row_ready))
        else $error("row_valid asserted while row_ready low: row dropped");

endmodule

// File: tb/tb_median_row_serializer.sv
// Bench for median_row_serializer: directed table, corner sequences, then random traffic vs a
// queue-of-rows model.
module tb_median_row_serializer;

    localparam int unsigned W = 4;
    localparam int unsigned R = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    median_row_serializer_if #(.WIDTH(W), .PIX_W(8)) bus ();

    median_row_serializer #(
        .WIDTH (W),
        .ROWS  (R),
        .PIX_W (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: queue of pending rows, position of the reader, and a one-cycle-late eof flag.
    logic [31:0] mq [$];
    int          mcol;
    int          mrow;
    logic        mfd;

    typedef struct {
        logic        rv;
        logic [31:0] row;
        logic        pr;
        logic        ev;
        logic [7:0]  ep;
        logic        eeol;
        logic        eeof;
        logic        erdy;
        logic        efd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcol = 0;
        mrow = 0;
        mfd  = 1'b0;
    endtask

    task automatic model_check();
        logic        v;
        logic        eol;
        logic [31:0] cur;
        v   = (mq.size() != 0);
        eol = v && (mcol == W - 1);
        chk("row_ready", {31'd0, bus.row_ready}, {31'd0, mq.size() < 2});
        chk("pix_valid", {31'd0, bus.pix_valid}, {31'd0, v});
        chk("pix_eol", {31'd0, bus.pix_eol}, {31'd0, eol});
        chk("pix_eof", {31'd0, bus.pix_eof}, {31'd0, eol && (mrow == R - 1)});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, mfd});
        if (v) begin
            cur = mq[0];
            chk("pix_out", {24'd0, bus.pix_out}, {24'd0, cur[8*mcol +: 8]});
        end
    endtask

    task automatic model_update(input logic rv, input logic [31:0] row, input logic pr);
        logic v, eof, rdy, pop;
        v   = (mq.size() != 0);
        eof = v && (mcol == W - 1) && (mrow == R - 1);
        rdy = (mq.size() < 2);
        pop = v && pr;
        mfd = pop && eof;
        if (pop) begin
            if (mcol == W - 1) begin
                void'(mq.pop_front());
                mcol = 0;
                mrow = (mrow + 1) % R;
            end else begin
                mcol++;
            end
        end
        if (rv && rdy) mq.push_back(row);
    endtask

    // Called at a falling edge: check current outputs, drive inputs for the next rising edge.
    task automatic step(input logic rv, input logic [31:0] row, input logic pr);
        model_check();
        bus.row_valid = rv;
        for (int i = 0; i < W; i++) bus.row_in[i] = row[8*i +: 8];
        bus.pix_ready = pr;
        model_update(rv, row, pr);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single row with 3-cycle stall at col 1, then a second row closing the frame.
        tbl[0]  = '{1'b1, 32'h13121110, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h23222120, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h23, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        bus.row_valid = 1'b0;
        bus.pix_ready = 1'b0;
        for (int i = 0; i < W; i++) bus.row_in[i] = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("reset_ready", {31'd0, bus.row_ready}, 32'd1);
        chk("reset_eol", {31'd0, bus.pix_eol}, 32'd0);
        chk("reset_eof", {31'd0, bus.pix_eof}, 32'd0);
        chk("reset_fdone", {31'd0, bus.frame_done}, 32'd0);

        foreach (tbl[k]) begin
            step(tbl[k].rv, tbl[k].row, tbl[k].pr);
            chk($sformatf("tbl%0d_valid", k), {31'd0, bus.pix_valid}, {31'd0, tbl[k].ev});
            if (tbl[k].ev) chk($sformatf("tbl%0d_pix", k), {24'd0, bus.pix_out}, {24'd0, tbl[k].ep});
            chk($sformatf("tbl%0d_eol", k), {31'd0, bus.pix_eol}, {31'd0, tbl[k].eeol});
            chk($sformatf("tbl%0d_eof", k), {31'd0, bus.pix_eof}, {31'd0, tbl[k].eeof});
            chk($sformatf("tbl%0d_ready", k), {31'd0, bus.row_ready}, {31'd0, tbl[k].erdy});
            chk($sformatf("tbl%0d_fdone", k), {31'd0, bus.frame_done}, {31'd0, tbl[k].efd});
        end

        // Ping-pong full: two rows back-to-back with the sink stalled.
        step(1'b1, 32'h33323130, 1'b0);
        step(1'b1, 32'h43424140, 1'b0);
        chk("pp_full_ready", {31'd0, bus.row_ready}, 32'd0);
        step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < W; i++) step(1'b0, 32'h0, 1'b1);
        chk("pp_release_ready", {31'd0, bus.row_ready}, 32'd1);
        chk("pp_b_first", {24'd0, bus.pix_out}, 32'h40);
        for (int i = 0; i < W - 1; i++) step(1'b0, 32'h0, 1'b1);

        // Accept on the same edge as the final pop: no bubble into the new row.
        step(1'b1, 32'h53525150, 1'b1);
        chk("sim_no_bubble", {24'd0, bus.pix_out}, 32'h50);
        chk("sim_occ_one", {31'd0, bus.row_ready}, 32'd1);
        for (int i = 0; i < W; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);

        // Reset mid-row at col 2.
        step(1'b1, 32'h63626160, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        bus.pix_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("mrst_ready", {31'd0, bus.row_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 32'hA3A2A1A0, 1'b1);
        chk("mrst_restart", {24'd0, bus.pix_out}, 32'hA0);
        for (int i = 0; i < W; i++) step(1'b0, 32'h0, 1'b1);

        // Random traffic; row_valid only offered when the model says a slot is free.
        for (int n = 0; n < 800; n++) begin
            logic        rv, pr;
            logic [31:0] row;
            rv  = ($urandom_range(0, 2) == 0) && (mq.size() < 2);
            pr  = ($urandom_range(0, 3) != 0);
            row = $urandom;
            step(rv, row, pr);
        end
        model_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
